// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte receiver: FSM states, default line
// parameters, the mid-bit sample points and the 2-of-3 vote.
package uart_pkg;

  localparam int unsigned DEF_CLK_FREQ   = 100_000_000;
  localparam int unsigned DEF_BAUD       = 115_200;
  localparam int unsigned DEF_OVERSAMPLE = 16;

  // Three samples straddling the bit centre; the vote is taken at the last one.
  localparam int unsigned SAMPLE_EARLY = 7;
  localparam int unsigned SAMPLE_MID   = 8;
  localparam int unsigned SAMPLE_LATE  = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..DIV-1 and pulses tick_o at DIV-1.
// Held at zero while hold_i is high so the first tick is aligned to the start edge.
module uart_baud_tick #(
  parameter int unsigned DIV = 54
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    tick_o = 1'b0;
    if (hold_i) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d  = '0;
      tick_o = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge value of its inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: synchronizes rx, majority-votes three samples per bit and
// emits one-cycle rx_ready / frame_err pulses per received frame.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
  parameter int unsigned BAUD       = DEF_BAUD,
  parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned DIV    = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned SCNT_W = $clog2(OVERSAMPLE);
  localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [SCNT_W-1:0] S_EARLY  = SCNT_W'(SAMPLE_EARLY);
  localparam logic [SCNT_W-1:0] S_MID    = SCNT_W'(SAMPLE_MID);
  localparam logic [SCNT_W-1:0] S_LATE   = SCNT_W'(SAMPLE_LATE);

  rx_state_e         state_q, state_d;
  logic              rx_meta_q, rx_sync_q;
  logic [SCNT_W-1:0] samp_cnt_q, samp_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              s_early_q, s_early_d;
  logic              s_mid_q, s_mid_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              rx_ready_q, rx_ready_d;
  logic              frame_err_q, frame_err_d;

  logic tick;
  logic hold_tick;
  logic bit_done;
  logic vote;

  assign hold_tick = (state_q == IDLE);

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold_i (hold_tick),
    .tick_o (tick)
  );

  assign bit_done = tick && (samp_cnt_q == S_LATE);
  assign vote     = majority3(s_early_q, s_mid_q, rx_sync_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (!rx_sync_q) state_d = START;
      START:     if (bit_done) state_d = vote ? IDLE : DATA;
      DATA:      if (bit_done && (bit_cnt_q == 3'd7)) state_d = STOP;
      STOP:      if (bit_done) state_d = vote ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rx_sync_q) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output logic: strobes are registered so they appear one clk after the vote
  always_comb begin
    busy        = (state_q != IDLE);
    rx_ready_d  = (state_q == STOP) && bit_done && vote;
    frame_err_d = (state_q == STOP) && bit_done && !vote;
  end

  always_comb begin
    samp_cnt_d = samp_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    s_early_d  = s_early_q;
    s_mid_d    = s_mid_q;
    rx_data_d  = rx_data_q;

    if (state_q == IDLE) begin
      samp_cnt_d = '0;
    end else if (tick) begin
      samp_cnt_d = (samp_cnt_q == SCNT_MAX) ? '0 : samp_cnt_q + 1'b1;
    end

    if (tick && (samp_cnt_q == S_EARLY)) s_early_d = rx_sync_q;
    if (tick && (samp_cnt_q == S_MID))   s_mid_d   = rx_sync_q;

    // LSB arrives first, so shifting right leaves it in bit 0 after eight bits
    if (state_q != DATA) begin
      bit_cnt_d = '0;
    end else if (bit_done) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
      shift_d   = {vote, shift_q[7:1]};
    end

    if (rx_ready_d) rx_data_d = shift_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      samp_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      s_early_q   <= 1'b0;
      s_mid_q     <= 1'b0;
      rx_data_q   <= '0;
      rx_ready_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      samp_cnt_q  <= samp_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      s_early_q   <= s_early_d;
      s_mid_q     <= s_mid_d;
      rx_data_q   <= rx_data_d;
      rx_ready_q  <= rx_ready_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_ready  = rx_ready_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx, run with a faster clock (DIV=8, 128 clk/bit)
// so every scenario, scaled to bit time, fits a short simulation.
module tb_uart_byte_rx;

  localparam int unsigned CLK_FREQ = 14_745_600;
  localparam int unsigned BAUD     = 115_200;
  localparam int unsigned OS       = 16;
  localparam int          DIV      = int'(CLK_FREQ / (BAUD * OS));
  localparam int          BIT      = DIV * int'(OS);
  // Start edge -> rx_ready: 2 sync flops + 1 IDLE->START edge, then 154 ticks (stop bit sample 9)
  localparam int          LATENCY  = 3 + 154 * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       frame_err;
  logic       busy;

  always #5 clk = ~clk;

  uart_byte_rx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .busy      (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: records every output event; only this block writes these variables.
  longint     cyc = 0;
  int         ready_cnt = 0;
  int         ferr_cnt = 0;
  int         busy_cyc = 0;
  int         overlap_viol = 0;
  int         wide_viol = 0;
  int         hold_viol = 0;
  longint     ready_cyc = 0;
  logic [7:0] got_q[$];
  logic       prev_ready = 1'b0;
  logic       prev_ferr = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_ready) begin
        ready_cnt++;
        got_q.push_back(rx_data);
        ready_cyc = cyc;
      end
      if (frame_err) ferr_cnt++;
      if (busy) busy_cyc++;
      if (rx_ready && frame_err) overlap_viol++;
      if ((rx_ready && prev_ready) || (frame_err && prev_ferr)) wide_viol++;
      if (!rx_ready && (rx_data != prev_data)) hold_viol++;
    end
    prev_ready = rx_ready;
    prev_ferr  = frame_err;
    prev_data  = rx_data;
  end

  function automatic int got_at(input int i);
    if (i < got_q.size()) return int'(got_q[i]);
    return -1;
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  longint frame_start_cyc;

  // Drives one 8N1 frame, one cycle per iteration just after each rising edge.
  // glitch_c inverts rx for two cycles; rst_c asserts reset at that cycle.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch_c,
                            input int rst_c);
    logic [9:0] fr;
    int         c;
    fr = {stop, d, 1'b0};
    frame_start_cyc = cyc;
    c = 0;
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < BIT; k++) begin
        if (c == rst_c) rst_n = 1'b0;
        rx = fr[0] ^ ((c == glitch_c) || (c == glitch_c + 1));
        @(posedge clk);
        #1;
        c++;
      end
      fr = fr >> 1;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_ready;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int r0, f0, b0, base, nexp, nbad, gap;
    logic [7:0] exp_q[$];
    logic [7:0] exp_last;
    logic [7:0] d;
    logic       stop;

    tbl[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    tbl[1] = '{8'h12, 1'b1, 1, 0, 8'h12};
    tbl[2] = '{8'hC3, 1'b0, 0, 1, 8'h12};
    tbl[3] = '{8'h80, 1'b1, 1, 0, 8'h80};
    tbl[4] = '{8'h01, 1'b0, 0, 1, 8'h80};
    tbl[5] = '{8'hFE, 1'b1, 1, 0, 8'hFE};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_data", int'(rx_data), 0);
    check("reset_rx_ready", int'(rx_ready), 0);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    idle(BIT);

    // Table-driven single frames
    for (int i = 0; i < 6; i++) begin
      r0 = ready_cnt;
      f0 = ferr_cnt;
      send_frame(tbl[i].data, tbl[i].stop, -10, -1);
      idle(BIT);
      check($sformatf("tbl%0d_ready", i), ready_cnt - r0, tbl[i].exp_ready);
      check($sformatf("tbl%0d_ferr", i), ferr_cnt - f0, tbl[i].exp_ferr);
      check($sformatf("tbl%0d_data", i), int'(rx_data), int'(tbl[i].exp_data));
    end

    // 0xA5 with exact latency from start edge to rx_ready
    r0 = ready_cnt;
    f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1, -10, -1);
    idle(BIT);
    check("a5_ready", ready_cnt - r0, 1);
    check("a5_data", int'(rx_data), 8'hA5);
    check("a5_ferr", ferr_cnt - f0, 0);
    check("a5_latency", int'(ready_cyc - frame_start_cyc), LATENCY);

    // Short low pulse on an idle line is rejected as a glitch
    r0 = ready_cnt;
    f0 = ferr_cnt;
    b0 = busy_cyc;
    rx = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
    end
    idle(2 * BIT);
    check("glitch_busy_seen", int'(busy_cyc > b0), 1);
    check("glitch_back_idle", int'(busy), 0);
    check("glitch_ready", ready_cnt - r0, 0);
    check("glitch_ferr", ferr_cnt - f0, 0);

    // Bad stop, 5-bit break, then a good frame
    r0 = ready_cnt;
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, -10, -1);
    check("break_ferr", ferr_cnt - f0, 1);
    check("break_data_kept", int'(rx_data), 8'hA5);
    r0 = ready_cnt;
    f0 = ferr_cnt;
    rx = 1'b0;
    repeat (5 * BIT) begin
      @(posedge clk);
      #1;
    end
    check("break_hold_ferr", ferr_cnt - f0, 0);
    check("break_hold_ready", ready_cnt - r0, 0);
    idle(BIT);
    send_frame(8'h01, 1'b1, -10, -1);
    idle(BIT);
    check("after_break_ready", ready_cnt - r0, 1);
    check("after_break_ferr", ferr_cnt - f0, 0);
    check("after_break_data", int'(rx_data), 8'h01);

    // Back-to-back frames
    r0 = ready_cnt;
    base = got_q.size();
    send_frame(8'h00, 1'b1, -10, -1);
    send_frame(8'hFF, 1'b1, -10, -1);
    send_frame(8'h55, 1'b1, -10, -1);
    idle(BIT);
    check("b2b_ready", ready_cnt - r0, 3);
    check("b2b_0", got_at(base), 8'h00);
    check("b2b_1", got_at(base + 1), 8'hFF);
    check("b2b_2", got_at(base + 2), 8'h55);

    // Two-cycle glitch landing on sample 8 of data bit 3
    r0 = ready_cnt;
    send_frame(8'hF0, 1'b1, 73 * DIV - 1, -1);
    idle(BIT);
    check("vote_ready", ready_cnt - r0, 1);
    check("vote_data", int'(rx_data), 8'hF0);

    // Reset during data bit 4 of 0x81, then a clean 0x7E
    r0 = ready_cnt;
    f0 = ferr_cnt;
    send_frame(8'h81, 1'b1, -10, 5 * BIT + 40);
    check("rst_rx_data", int'(rx_data), 0);
    check("rst_rx_ready", int'(rx_ready), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_busy", int'(busy), 0);
    rx = 1'b1;
    rst_n = 1'b1;
    idle(BIT);
    check("rst_no_pulse", ready_cnt - r0, 0);
    send_frame(8'h7E, 1'b1, -10, -1);
    idle(BIT);
    check("post_rst_ready", ready_cnt - r0, 1);
    check("post_rst_ferr", ferr_cnt - f0, 0);
    check("post_rst_data", int'(rx_data), 8'h7E);

    // Random frames against a frame-level model: good stop -> byte delivered, bad -> one error
    r0 = ready_cnt;
    f0 = ferr_cnt;
    base = got_q.size();
    nbad = 0;
    exp_last = 8'h7E;
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 4) != 0);
      send_frame(d, stop, -10, -1);
      if (stop) begin
        exp_q.push_back(d);
        exp_last = d;
        gap = int'($urandom_range(0, 2));
      end else begin
        nbad++;
        gap = int'($urandom_range(1, 2));
      end
      idle(gap * BIT);
    end
    idle(BIT);
    nexp = exp_q.size();
    check("rand_ready", ready_cnt - r0, nexp);
    check("rand_ferr", ferr_cnt - f0, nbad);
    for (int i = 0; i < nexp; i++) begin
      check($sformatf("rand_byte%0d", i), got_at(base + i), int'(exp_q[i]));
    end
    check("rand_last_data", int'(rx_data), int'(exp_last));

    // Whole-run properties
    check("never_overlap", overlap_viol, 0);
    check("one_cycle_pulses", wide_viol, 0);
    check("data_held", hold_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_byte_rx.md
UART_BYTE_RX -- requirements
Module: uart_byte_rx

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate.
REQ-003 Parameter OVERSAMPLE, default 16, oversample ticks per bit.
REQ-004 Port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-006 Port rx  input  1  raw asynchronous serial line; idles high; 8N1, LSB first.
REQ-007 Port rx_data  output  8  last correctly framed byte.
REQ-008 Port rx_ready  output  1  one-cycle pulse; rx_data is valid in the same cycle.
REQ-009 Port frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-010 Port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer before any use; both flops reset to 1.
REQ-012 DIV SHALL be CLK_FREQ/(BAUD*OVERSAMPLE), truncated; the defaults give DIV=54 and a bit time of 864 cycles.
REQ-013 The tick counter SHALL count 0..DIV-1 and pulse tick at DIV-1; it SHALL be held at 0 in IDLE, so it is aligned to the start edge.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-015 IDLE: on synchronized rx == 0, the FSM SHALL go to START and clear the sample counter (0..OVERSAMPLE-1).
REQ-016 Each bit value SHALL be the majority of samples taken at sample counts 7, 8 and 9.
REQ-017 START: at sample count 9, majority 0 SHALL go to DATA; majority 1 SHALL return to IDLE as a rejected glitch, with no output pulse.
REQ-018 DATA: one bit SHALL be taken per OVERSAMPLE ticks and shifted LSB-first into the shift register; a 3-bit bit counter SHALL go to STOP after bit 7.
REQ-019 STOP: majority 1 SHALL load rx_data from the shift register, pulse rx_ready on the next clk, and go to IDLE.
REQ-020 STOP: majority 0 SHALL pulse frame_err, leave rx_data unchanged, suppress rx_ready, and go to WAIT_HIGH.
REQ-021 WAIT_HIGH SHALL stay put until synchronized rx == 1, then go to IDLE; this means a break condition produces exactly one frame_err.
REQ-022 rx_ready and frame_err SHALL never assert in the same cycle, and each SHALL be high for exactly one clk per byte.
REQ-023 rx_data SHALL hold its value between rx_ready pulses.
REQ-024 Latency: rx_ready SHALL rise exactly 1 clk after the tick at stop-bit sample count 9.
REQ-025 Back-to-back frames with one stop bit SHALL be received without loss, because the FSM leaves STOP before the stop bit ends.
REQ-026 There is no flow control: the consumer SHALL accept rx_ready unconditionally (the weight loader does so).

Reset
REQ-027 rst_n low SHALL immediately force: FSM to IDLE; rx_data=0; rx_ready=0; frame_err=0; busy=0; all counters and the shift register to 0; synchronizer flops to 1.
REQ-028 Reset asserted mid-frame SHALL discard the partial byte and produce no output pulse.
REQ-029 After rst_n rises, the first complete frame SHALL be received normally.

Structure
REQ-030 Package uart_pkg SHALL hold the state enum, the default CLK_FREQ/BAUD/OVERSAMPLE constants, and the 7/8/9 sample-point constants.
REQ-031 Sub-module uart_baud_tick SHALL contain the DIV counter and tick pulse, with a hold input driven by (state == IDLE).
REQ-032 The implementation SHALL be synthesizable with no latches and no multicycle paths.

Verification (defaults, 864 clk/bit)
REQ-033 Send 0xA5 -> exactly one rx_ready pulse, rx_data=0xA5, frame_err never high.
REQ-034 Drive rx low for 200 clk on an idle line -> busy pulses, FSM returns to IDLE, no rx_ready and no frame_err.
REQ-035 Send 0x3C with stop bit 0, then hold rx low for 5 bit times, then send 0x01 -> one frame_err pulse, rx_data stays 0xA5, no events during the low hold, then rx_ready with rx_data=0x01.
REQ-036 Send 0x00, 0xFF, 0x55 back-to-back -> three rx_ready pulses in order, with rx_data values 0x00, 0xFF, 0x55.
REQ-037 Invert rx for 2 clk around sample count 8 of bit 3 while sending 0xF0 -> rx_data=0xF0, because the majority vote rejects the glitch.
REQ-038 Pull rst_n low during bit 4 of 0x81, release it, then send 0x7E -> all outputs 0 during reset, no pulse for 0x81, then rx_ready with rx_data=0x7E.
